// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver in the system clock domain.
// Configurable data width, parity and stop bits; reports parity/frame/break.
module uart_rx_os #(
    parameter int CLOCK_FREQUENCY = 50_000_000,
    parameter int BAUD_RATE       = 115200,
    parameter int OVERSAMPLE      = 16,
    parameter int DATA_BITS       = 8,
    parameter int PARITY          = 2,
    parameter int STOP_BITS       = 1
) (
    input  logic                 clockIN,
    input  logic                 nRxResetIN,
    input  logic                 rxIN,
    output logic                 rxIdleOUT,
    output logic                 rxReadyOUT,
    output logic [DATA_BITS-1:0] rxDataOUT,
    output logic                 rxParityErrOUT,
    output logic                 rxFrameErrOUT,
    output logic                 rxBreakOUT
);
    localparam int TICK_DIV   = CLOCK_FREQUENCY / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int OS_W       = $clog2(OVERSAMPLE);
    localparam int PAR_BITS   = (PARITY != 0) ? 1 : 0;
    localparam int FRAME_BITS = 1 + DATA_BITS + PAR_BITS + STOP_BITS;
    localparam int BIT_W      = $clog2(FRAME_BITS);

    localparam logic [DIV_W-1:0] DIV_MAX   = DIV_W'(TICK_DIV - 1);
    localparam logic [OS_W-1:0]  HALF      = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  FULL      = OS_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t               state;
    logic [1:0]           sync;
    logic [1:0]           hist;
    logic                 rx_f;
    logic [DIV_W-1:0]     div_cnt;
    logic                 tick;
    logic                 start_edge;
    logic [OS_W-1:0]      os_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 exp_par;
    logic                 perr;
    logic                 ferr;
    logic                 stop_ferr;

    // Two-flop synchroniser followed by a three-tap history for voting
    always_ff @(posedge clockIN) begin
        if (!nRxResetIN) begin
            sync <= 2'b11;
            hist <= 2'b11;
        end else begin
            sync <= {sync[0], rxIN};
            hist <= {hist[0], sync[1]};
        end
    end

    assign rx_f = (sync[1] & hist[0]) | (sync[1] & hist[1]) | (hist[0] & hist[1]);

    assign start_edge = (state == S_IDLE) && !rx_f;
    assign tick       = (div_cnt == '0) && !start_edge;
    assign exp_par    = (PARITY == 1) ? ^shreg : ~^shreg;
    assign stop_ferr  = ferr | !rx_f;
    assign rxIdleOUT  = (state == S_IDLE);

    // Oversample tick: down-counter re-phased on the start edge
    always_ff @(posedge clockIN) begin
        if (!nRxResetIN) begin
            div_cnt <= '0;
        end else if (start_edge || div_cnt == '0) begin
            div_cnt <= DIV_MAX;
        end else begin
            div_cnt <= div_cnt - 1'b1;
        end
    end

    // Frame FSM: samples mid-bit and registers the word with its flags
    always_ff @(posedge clockIN) begin
        if (!nRxResetIN) begin
            state          <= S_IDLE;
            os_cnt         <= '0;
            bit_cnt        <= '0;
            shreg          <= '0;
            par_bit        <= 1'b0;
            perr           <= 1'b0;
            ferr           <= 1'b0;
            rxReadyOUT     <= 1'b0;
            rxDataOUT      <= '0;
            rxParityErrOUT <= 1'b0;
            rxFrameErrOUT  <= 1'b0;
            rxBreakOUT     <= 1'b0;
        end else begin
            rxReadyOUT <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (!rx_f) begin
                        state  <= S_START;
                        os_cnt <= '0;
                    end
                end
                S_START: begin
                    if (tick) begin
                        if (os_cnt == HALF) begin
                            os_cnt  <= '0;
                            bit_cnt <= '0;
                            par_bit <= 1'b0;
                            perr    <= 1'b0;
                            ferr    <= 1'b0;
                            state   <= rx_f ? S_IDLE : S_DATA;
                        end else begin
                            os_cnt <= os_cnt + 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        if (os_cnt == FULL) begin
                            os_cnt <= '0;
                            shreg  <= {rx_f, shreg[DATA_BITS-1:1]};
                            if (bit_cnt == LAST_DATA) begin
                                bit_cnt <= '0;
                                state   <= (PARITY == 0) ? S_STOP : S_PAR;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            os_cnt <= os_cnt + 1'b1;
                        end
                    end
                end
                S_PAR: begin
                    if (tick) begin
                        if (os_cnt == FULL) begin
                            os_cnt  <= '0;
                            par_bit <= rx_f;
                            perr    <= (rx_f != exp_par);
                            state   <= S_STOP;
                        end else begin
                            os_cnt <= os_cnt + 1'b1;
                        end
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        if (os_cnt == FULL) begin
                            os_cnt <= '0;
                            if (bit_cnt == LAST_STOP) begin
                                bit_cnt        <= '0;
                                rxReadyOUT     <= 1'b1;
                                rxDataOUT      <= shreg;
                                rxParityErrOUT <= perr;
                                rxFrameErrOUT  <= stop_ferr;
                                rxBreakOUT     <= stop_ferr && (shreg == '0) && !par_bit;
                                state          <= rx_f ? S_IDLE : S_WAIT_HIGH;
                            end else begin
                                ferr    <= stop_ferr;
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            os_cnt <= os_cnt + 1'b1;
                        end
                    end
                end
                S_WAIT_HIGH: begin
                    if (rx_f) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed frames against three receiver configurations.
// 8O1 default, 8E1, and 7N2; expected values are hand-computed.
module tb_uart_rx_os;
    localparam int BIT = 432;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] rx_line = 3'b111;

    logic       idle0, rdy0, perr0, ferr0, brk0;
    logic [7:0] data0;
    logic       idle1, rdy1, perr1, ferr1, brk1;
    logic [7:0] data1;
    logic       idle2, rdy2, perr2, ferr2, brk2;
    logic [6:0] data2;

    int n0 = 0;
    int n1 = 0;
    int n2 = 0;
    int tests = 0;
    int fails = 0;
    int b0, b1, b2;

    always #5 clk = ~clk;

    uart_rx_os u_dut (
        .clockIN(clk), .nRxResetIN(rst_n), .rxIN(rx_line[0]),
        .rxIdleOUT(idle0), .rxReadyOUT(rdy0), .rxDataOUT(data0),
        .rxParityErrOUT(perr0), .rxFrameErrOUT(ferr0), .rxBreakOUT(brk0)
    );

    uart_rx_os #(.PARITY(1)) u_even (
        .clockIN(clk), .nRxResetIN(rst_n), .rxIN(rx_line[1]),
        .rxIdleOUT(idle1), .rxReadyOUT(rdy1), .rxDataOUT(data1),
        .rxParityErrOUT(perr1), .rxFrameErrOUT(ferr1), .rxBreakOUT(brk1)
    );

    uart_rx_os #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
        .clockIN(clk), .nRxResetIN(rst_n), .rxIN(rx_line[2]),
        .rxIdleOUT(idle2), .rxReadyOUT(rdy2), .rxDataOUT(data2),
        .rxParityErrOUT(perr2), .rxFrameErrOUT(ferr2), .rxBreakOUT(brk2)
    );

    // Count ready cycles; a stretched pulse shows up as an extra count
    always @(posedge clk) begin
        if (rdy0) n0++;
        if (rdy1) n1++;
        if (rdy2) n2++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int idx, input bit v, input int clocks);
        rx_line[idx] = v;
        repeat (clocks) @(negedge clk);
    endtask

    task automatic send(input int idx, input logic [8:0] d, input int nb,
                        input bit hp, input bit pb, input int ns, input bit sv);
        drive(idx, 1'b0, BIT);
        for (int i = 0; i < nb; i++) drive(idx, d[i], BIT);
        if (hp) drive(idx, pb, BIT);
        for (int i = 0; i < ns; i++) drive(idx, sv, BIT);
        drive(idx, 1'b1, BIT);
    endtask

    initial begin
        repeat (4) @(negedge clk);
        chk("rst idle", idle0, 1);
        chk("rst ready", rdy0, 0);
        chk("rst data", data0, 8'h00);
        chk("rst perr", perr0, 0);
        chk("rst ferr", ferr0, 0);
        chk("rst brk", brk0, 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // 0xA5, 8O1: four ones -> parity bit 1
        b0 = n0;
        send(0, 9'h0A5, 8, 1, 1, 1, 1);
        chk("a5 pulses", n0 - b0, 1);
        chk("a5 data", data0, 8'hA5);
        chk("a5 perr", perr0, 0);
        chk("a5 ferr", ferr0, 0);
        chk("a5 brk", brk0, 0);
        chk("a5 idle", idle0, 1);

        // 0x37, 8E1: five ones -> correct bit 1, send 0
        b1 = n1;
        send(1, 9'h037, 8, 1, 0, 1, 1);
        chk("37 pulses", n1 - b1, 1);
        chk("37 data", data1, 8'h37);
        chk("37 perr", perr1, 1);
        chk("37 ferr", ferr1, 0);

        // 0x5A, 8O1 with stop bit forced low
        b0 = n0;
        send(0, 9'h05A, 8, 1, 1, 1, 0);
        chk("5a pulses", n0 - b0, 1);
        chk("5a data", data0, 8'h5A);
        chk("5a ferr", ferr0, 1);
        chk("5a brk", brk0, 0);
        chk("5a perr", perr0, 0);

        // 100-clock glitch: false start, no pulse
        b0 = n0;
        drive(0, 1'b0, 100);
        drive(0, 1'b1, 2 * BIT);
        chk("glitch pulses", n0 - b0, 0);
        chk("glitch idle", idle0, 1);
        chk("glitch data held", data0, 8'h5A);

        b0 = n0;
        send(0, 9'h03C, 8, 1, 1, 1, 1);
        chk("3c pulses", n0 - b0, 1);
        chk("3c data", data0, 8'h3C);
        chk("3c ferr", ferr0, 0);

        // Line held low for 20 bit times: one break frame
        b0 = n0;
        drive(0, 1'b0, 20 * BIT);
        chk("brk pulses", n0 - b0, 1);
        chk("brk idle low", idle0, 0);
        chk("brk data", data0, 8'h00);
        chk("brk flag", brk0, 1);
        chk("brk ferr", ferr0, 1);
        chk("brk perr", perr0, 1);
        drive(0, 1'b1, 2 * BIT);
        chk("brk no repeat", n0 - b0, 1);
        chk("brk idle", idle0, 1);

        // 0x81, 8O1: two ones -> parity bit 1
        b0 = n0;
        send(0, 9'h081, 8, 1, 1, 1, 1);
        chk("81 pulses", n0 - b0, 1);
        chk("81 data", data0, 8'h81);
        chk("81 brk", brk0, 0);
        chk("81 ferr", ferr0, 0);

        // 0x41, 7N2
        b2 = n2;
        send(2, 9'h041, 7, 0, 0, 2, 1);
        chk("41 pulses", n2 - b2, 1);
        chk("41 data", data2, 7'h41);
        chk("41 ferr", ferr2, 0);
        chk("41 perr", perr2, 0);

        // Reset mid-frame (line high in bit 0) abandons the frame
        b2 = n2;
        drive(2, 1'b0, BIT);
        drive(2, 1'b1, BIT / 2);
        chk("mid idle", idle2, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mrst idle", idle2, 1);
        chk("mrst data", data2, 7'h00);
        chk("mrst ready", rdy2, 0);
        chk("mrst ferr", ferr2, 0);
        chk("mrst brk", brk2, 0);
        drive(2, 1'b1, 12 * BIT);
        chk("mrst pulses", n2 - b2, 0);
        chk("mrst idle after", idle2, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
Parametrised successor to the existing single-format UART receiver. It runs entirely in the system clock domain, using an oversampling tick enable instead of a derived baud clock. Data width, parity mode and stop-bit count are configurable. It reports parity, framing and break conditions alongside each received word. It sits between the board RX pin and the command/packet parser.

Parameters:
CLOCK_FREQUENCY, 50_000_000, system clock frequency in Hz
BAUD_RATE, 115200, line rate in bit/s
OVERSAMPLE, 16, ticks per bit; must be even and at least 8
DATA_BITS, 8, data bits per frame; legal range 5..9
PARITY, 2, parity mode: 0 none, 1 even, 2 odd
STOP_BITS, 1, stop bits per frame: 1 or 2

Ports:
clockIN  input  1  system clock; the only clock in the block
nRxResetIN  input  1  reset, synchronous to clockIN, active-low
rxIN  input  1  asynchronous serial line; idle level is 1
rxIdleOUT  output  1  1 when the FSM is in IDLE
rxReadyOUT  output  1  one-clock pulse: word and flags are valid
rxDataOUT  output  DATA_BITS  last received word, LSB = first bit on the line
rxParityErrOUT  output  1  parity mismatch on last word; 0 when PARITY=0
rxFrameErrOUT  output  1  a stop bit was sampled as 0 on last word
rxBreakOUT  output  1  last frame was all-zero including the stop bit(s)

Behaviour:
- Reset: synchronous, active-low, sampled on posedge clockIN, overrides everything.
  - Reset values: rxIdleOUT=1, rxReadyOUT=0, rxDataOUT=0, all error flags 0.
  - FSM goes to IDLE; tick counter and bit counter go to 0.
  - Reset asserted mid-frame abandons the frame and produces no ready pulse.
- Input conditioning:
  - rxIN passes through a 2-FF synchroniser, then a 3-tap majority vote, producing rx_f.
  - rxIN to rx_f latency is 3 clocks; synchroniser FFs reset to 1.
- Tick generator:
  - TICK_DIV = CLOCK_FREQUENCY/(BAUD_RATE*OVERSAMPLE), integer division.
  - A down-counter emits a 1-clock tick each time it wraps.
  - The counter reloads on the clock where a start edge is detected, to align phase.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE: when rx_f==0, go to START and clear the tick count.
  - START: after OVERSAMPLE/2 ticks, sample rx_f at mid-bit.
    - If 1: false start; return to IDLE with no output.
    - If 0: go to DATA.
  - DATA: sample every OVERSAMPLE ticks and shift in LSB-first; after DATA_BITS samples go to PARITY, or to STOP when PARITY=0.
  - PARITY: one sample. Expected bit is XOR of data (even) or its inverse (odd); a mismatch sets the internal perr.
  - STOP: STOP_BITS samples, OVERSAMPLE ticks apart; any 0 sample sets the internal ferr.
    - On the last stop sample: load rxDataOUT and all flags, pulse rxReadyOUT for exactly 1 clock.
    - Then go to IDLE if rx_f==1, else WAIT_HIGH.
  - WAIT_HIGH: stay until rx_f==1, then go to IDLE. This prevents re-triggering on a held-low line.
- Output flags:
  - rxBreakOUT = ferr AND all data bits 0 AND (parity bit 0 or PARITY=0).
  - A break also sets rxFrameErrOUT.
  - Data and all flags hold until the next ready pulse; they are not cleared by the next start bit.
- Back-to-back frames: a start bit immediately after the stop sample is accepted once the FSM reaches IDLE. No gap beyond the remaining half stop bit is required.
- Frame length: 1 start + DATA_BITS + parity + STOP_BITS; the bit counter is sized by $clog2.

Test Plan:
- Frame 0xA5 at default parameters (8O1; TICK_DIV=27, 432 clocks/bit) -> exactly one rxReadyOUT pulse; rxDataOUT=0xA5; all flags 0; rxIdleOUT=1 afterwards.
- Frame 0x37 with PARITY=1 and the parity bit forced wrong -> rxDataOUT=0x37, rxParityErrOUT=1, rxFrameErrOUT=0.
- Frame 0x5A with the stop bit forced to 0 -> rxFrameErrOUT=1, rxDataOUT=0x5A, rxBreakOUT=0, and a single ready pulse.
- Low glitch of 100 clocks (< half-bit of 216) -> no ready pulse; FSM returns to IDLE; next valid frame 0x3C is received correctly.
- Line held low for 20 bit times -> one ready pulse with rxDataOUT=0x00 and rxBreakOUT=1, rxFrameErrOUT=1; no further pulse until the line returns high and a new frame 0x81 arrives.
- DATA_BITS=7, PARITY=0, STOP_BITS=2, frame 0x41 -> rxDataOUT=0x41 after both stop bits. Then assert nRxResetIN for 1 clock mid-way through a second frame -> outputs go to reset values and no ready pulse is produced.
